// File: rtl/d_flip_flop.sv
// Parameterized D-type storage register with asynchronous active-low reset.
// Cascade instances with nreset tied high to build delay lines or synchronizers.
module d_flip_flop #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= d;
        end
    end

    // Both outputs derive from the same register so qn never shows a transient equal to q.
    assign q  = r_q;
    assign qn = ~r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: directed scenarios, a 2-stage chain,
// and randomized stimulus compared against a behavioural model.
module tb_d_flip_flop;

    logic       clock;
    logic       rn1, rn8;
    logic       d1, dc;
    logic [7:0] d8;
    logic       q1, qn1;
    logic [7:0] q8, qn8;
    logic       qa, qna, qb, qnb;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        cmp_en = 1'b0;

    d_flip_flop u1 (
        .clock(clock), .nreset(rn1), .d(d1), .q(q1), .qn(qn1)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
        .clock(clock), .nreset(rn8), .d(d8), .q(q8), .qn(qn8)
    );

    d_flip_flop u_sync0 (
        .clock(clock), .nreset(1'b1), .d(dc), .q(qa), .qn(qna)
    );

    d_flip_flop u_sync1 (
        .clock(clock), .nreset(1'b1), .d(qa), .q(qb), .qn(qnb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: value captured at the last edge, forced to reset value while reset is low.
    logic       m1;
    logic [7:0] m8;
    logic       h1, h2;
    initial begin
        m1 = 1'b0; m8 = 8'h00; h1 = 1'b0; h2 = 1'b0;
    end
    always @(posedge clock) begin
        m1 = rn1 ? d1 : 1'b0;
        m8 = rn8 ? d8 : 8'hA5;
        h2 = h1;
        h1 = dc;
    end
    always @(negedge rn1) m1 = 1'b0;
    always @(negedge rn8) m8 = 8'hA5;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_all();
        chk("rnd_q1",  {7'b0, q1},  {7'b0, m1});
        chk("rnd_qn1", {7'b0, qn1}, {7'b0, ~m1});
        chk("rnd_q8",  q8,  m8);
        chk("rnd_qn8", qn8, ~m8);
        chk("rnd_qa",  {7'b0, qa},  {7'b0, h1});
        chk("rnd_qb",  {7'b0, qb},  {7'b0, h2});
        chk("rnd_qnb", {7'b0, qnb}, {7'b0, ~h2});
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (cmp_en) cmp_all();
            #8;
            if (cmp_en) cmp_all();
        end
    end

    initial begin
        logic [7:0] vals [3];
        logic [7:0] prev;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h3C;

        rn1 = 1'b1; rn8 = 1'b1; d1 = 1'b0; d8 = 8'h00; dc = 1'b0;
        #1;
        rn1 = 1'b0; rn8 = 1'b0;
        #1;
        chk("rst_q1",  {7'b0, q1},  8'h00);
        chk("rst_qn1", {7'b0, qn1}, 8'h01);
        chk("rst_q8",  q8,  8'hA5);
        chk("rst_qn8", qn8, 8'h5A);
        chk("model_rst_m8", m8, 8'hA5);

        // Reset held low across an edge with d high.
        @(negedge clock);
        d1 = 1'b1;
        @(posedge clock); #1;
        chk("rst_priority_q1", {7'b0, q1}, 8'h00);
        @(negedge clock);
        rn1 = 1'b1; rn8 = 1'b1;
        #1;
        chk("release_hold_q1", {7'b0, q1}, 8'h00);
        chk("release_hold_q8", q8, 8'hA5);
        @(posedge clock); #1;
        chk("release_cap_q1", {7'b0, q1}, 8'h01);
        chk("release_cap_q8", q8, 8'h00);
        chk("model_cap_m1", {7'b0, m1}, 8'h01);

        // Basic capture latency.
        @(negedge clock);
        d1 = 1'b0;
        #1;
        chk("cap_before_edge", {7'b0, q1}, 8'h01);
        @(posedge clock); #1;
        chk("cap_after_edge0", {7'b0, q1}, 8'h00);
        @(negedge clock);
        d1 = 1'b1;
        #1;
        chk("cap_before_edge1", {7'b0, q1}, 8'h00);
        @(posedge clock); #1;
        chk("cap_after_edge1", {7'b0, q1}, 8'h01);

        // Asynchronous reset mid-cycle.
        @(negedge clock);
        #2 rn1 = 1'b0;
        #1;
        chk("async_q1",  {7'b0, q1},  8'h00);
        chk("async_qn1", {7'b0, qn1}, 8'h01);
        @(negedge clock);
        rn1 = 1'b1;
        @(posedge clock); #1;
        chk("async_recover_q1", {7'b0, q1}, 8'h01);

        // Wide stream with non-zero reset value.
        prev = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            d8 = vals[i];
            #1;
            chk("stream_before", q8, prev);
            @(posedge clock); #1;
            chk("stream_q8",  q8,  vals[i]);
            chk("stream_qn8", qn8, ~vals[i]);
            prev = vals[i];
        end
        @(negedge clock);
        #2 rn8 = 1'b0;
        #1;
        chk("wide_async_q8",  q8,  8'hA5);
        chk("wide_async_qn8", qn8, 8'h5A);
        @(negedge clock);
        rn8 = 1'b1;

        // Glitches on d between edges are ignored.
        @(negedge clock);
        d1 = 1'b1;
        #1 d1 = 1'b0;
        #2 d1 = 1'b1;
        @(posedge clock); #1;
        chk("glitch_low_q1", {7'b0, q1}, 8'h01);
        @(negedge clock);
        d1 = 1'b0;
        @(posedge clock); #1;
        chk("glitch_pre_q1", {7'b0, q1}, 8'h00);
        @(negedge clock);
        #1 d1 = 1'b1;
        #2 d1 = 1'b0;
        @(posedge clock); #1;
        chk("glitch_high_q1", {7'b0, q1}, 8'h00);

        // Two-stage synchronizer chain.
        @(negedge clock);
        dc = 1'b1;
        #1;
        chk("chain_pre_qa", {7'b0, qa}, 8'h00);
        chk("chain_pre_qb", {7'b0, qb}, 8'h00);
        @(posedge clock); #1;
        chk("chain_k_qa", {7'b0, qa}, 8'h01);
        chk("chain_k_qb", {7'b0, qb}, 8'h00);
        @(posedge clock); #1;
        chk("chain_k1_qb", {7'b0, qb}, 8'h01);
        chk("chain_k1_qnb", {7'b0, qnb}, 8'h00);

        // Randomized phase with mid-cycle reset pulses.
        @(negedge clock);
        cmp_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            dc = 1'($urandom);
            #2;
            if (rn8 && ($urandom_range(0, 15) == 0)) rn8 = 1'b0;
            else if (!rn8 && ($urandom_range(0, 1) == 0)) rn8 = 1'b1;
            if (rn1 && ($urandom_range(0, 15) == 0)) rn1 = 1'b0;
            else if (!rn1 && ($urandom_range(0, 1) == 0)) rn1 = 1'b1;
        end
        @(negedge clock);
        cmp_en = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
Single-clock, parameterized D-type storage register with asynchronous active-low reset. It is the basic storage primitive of the design. Debounce and synchronizer chains cascade instances of it: each instance adds exactly one clock of delay, and two back-to-back instances form a 2-stage metastability synchronizer. In that use, nreset is tied high, so the block must behave as a plain register when reset is never asserted.

Parameters:
WIDTH, 1, bit width of d, q and qn.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while nreset is low.

Ports:
clock  input  1  sole clock; all state updates on rising edge.
nreset  input  1  asynchronous, active-low reset; may be tied constant 1.
d  input  WIDTH  data sampled on each rising clock edge.
q  output  WIDTH  registered data.
qn  output  WIDTH  bitwise complement of q; always equals ~q, with no extra state; may be left unconnected.

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port is named clock, reset port is named nreset.
- Reset assertion:
  - q takes RESET_VALUE immediately when nreset falls, with no clock edge required.
  - q holds RESET_VALUE for as long as nreset is low, regardless of clock and d.
- Reset release:
  - Release is synchronous in effect: q stays RESET_VALUE until the first rising clock edge with nreset high.
  - At that edge, q takes the value of d sampled at that edge.
- Normal operation (nreset high):
  - On every rising clock edge, q takes d. Latency is exactly 1 cycle.
  - No enable; q updates unconditionally every edge.
  - Between edges, q is stable regardless of d glitches.
- Reset mid-operation: asserting nreset between edges overrides the pending sample. Any d value present is discarded.
- Simultaneous events: if nreset is low at a clock edge, reset wins and q = RESET_VALUE.
- Power-up with nreset tied high:
  - Initial q is RESET_VALUE; an initial block is acceptable for simulation and FPGA init.
  - From the first clock edge onward, q follows d with 1-cycle delay.
- qn changes in the same delta as q and never shows a transient equal to q.
- Width rule: every bit is independent; no arithmetic and no wrap-around.
- Cascade rule: a chain of N instances with nreset high delivers d to the last q after exactly N rising edges.

Decomposition:
- No shared package is needed. RESET_VALUE is a per-instance parameter.
- No sub-module: a single always block, sensitive to posedge clock and negedge nreset, plus a continuous assign for qn.
- A companion bench must also build a 2-instance chain to verify synchronizer use.

Test Plan:
1. Async reset: WIDTH=1, q=1, drop nreset mid-cycle -> q=0 within the same timestep with no clock edge; qn=1.
2. Basic capture: nreset=1, d=1 set before edge k -> q=1 just after edge k and not before; d back to 0 -> q=0 after edge k+1.
3. Reset priority: nreset low across a rising edge with d=1 -> q stays 0. Release nreset mid-cycle -> q=0 until next edge, then q=1.
4. Wide and non-zero reset: WIDTH=8, RESET_VALUE=8'hA5, reset -> q=8'hA5, qn=8'h5A. Stream d=8'h00, 8'hFF, 8'h3C -> q lags by exactly one edge each.
5. Glitch immunity: nreset=1, pulse d high for a fraction of a cycle between edges -> q unchanged.
6. Two-stage chain, nreset tied 1: d steps 0->1 before edge k -> first q=1 after edge k, second q=1 after edge k+1, second q=0 before that.
